// File: rtl/rrpe_pkg.sv
// Shared constants and helpers for the rr_priority_encoder block.
// Optional feature macro used by the block: RRPE_LOCK_EN (adds the lock input).
package rrpe_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Increment modulo n using an explicit compare, so non-power-of-2 n wraps
    // at n-1 instead of at the next power of two.
    function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
        return (v == n - 1) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/rrpe_pick.sv
// Combinational selector: finds the first requesting line starting at i_start,
// wrapping N-1 -> 0. Round-robin order searches the rotated vector lowest-first;
// fixed order searches it highest-first (callers tie i_start to 0 in that mode).
// Optional feature macro of the enclosing block: RRPE_LOCK_EN (not used here).
module rrpe_pick
    import rrpe_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_start,
    output logic [IDXW-1:0] o_idx,
    output logic            o_found
);

    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic [IDXW-1:0] w_pos;
    logic [IDXW:0]   w_sum;

    // Rotate req right by i_start via the doubled vector so bit 0 of w_rot is line i_start.
    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = w_dbl[int'(i_start) + k];
        end
    end

    // Search the rotated vector in the order the arbitration mode requires.
    always_comb begin
        w_pos = '0;
        if (MODE == MODE_RR) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (w_rot[k]) w_pos = IDXW'(k);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_rot[k]) w_pos = IDXW'(k);
            end
        end
    end

    // Undo the rotation: (start + pos) mod N with an explicit compare for odd N.
    always_comb begin
        w_sum = {1'b0, i_start} + {1'b0, w_pos};
        if (w_sum >= (IDXW+1)'(N)) begin
            o_idx = IDXW'(w_sum - (IDXW+1)'(N));
        end else begin
            o_idx = w_sum[IDXW-1:0];
        end
    end

    assign o_found = |i_req;

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder / arbiter with a valid/ready output stage.
// MODE 0: highest requesting index wins. MODE 1: rotating round-robin pointer.
// Define RRPE_LOCK_EN to add the lock input, which re-grants the current line
// after a fire as long as that line is still requesting.
module rr_priority_encoder
    import rrpe_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef RRPE_LOCK_EN
    input  logic            lock,
`endif
    input  logic [N-1:0]    req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    out_onehot,
    output logic            idle
);

    logic            r_valid;
    logic [IDXW-1:0] r_idx;
    logic [N-1:0]    r_onehot;

    logic            w_fire;
    logic            w_load;
    logic            w_hold;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_pick_found;
    logic [IDXW-1:0] w_sel;
    logic [N-1:0]    w_sel_onehot;

    assign w_fire = r_valid & out_ready;
    assign w_load = (~r_valid | out_ready) & w_pick_found;

    // A locked fire keeps the same line if it is still asserting its request.
`ifdef RRPE_LOCK_EN
    assign w_hold = w_fire & lock & req[r_idx];
`else
    assign w_hold = 1'b0;
`endif

    generate
        if (MODE == MODE_RR) begin : g_ptr
            logic [IDXW-1:0] r_ptr;

            // Next pointer: one past the line that just fired, unless the grant is locked.
            always_comb begin
                w_ptr_nxt = r_ptr;
                if (w_fire && !w_hold) begin
                    w_ptr_nxt = IDXW'(inc_mod(32'(r_idx), 32'(N)));
                end
            end

            // Pointer register follows the next-pointer value every cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end else begin : g_no_ptr
            // Fixed priority always searches from line 0, highest-first.
            assign w_ptr_nxt = '0;
        end
    endgenerate

    rrpe_pick #(
        .N    (N),
        .IDXW (IDXW),
        .MODE (MODE)
    ) u_pick (
        .i_req   (req),
        .i_start (w_ptr_nxt),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_sel        = w_hold ? r_idx : w_pick_idx;
    assign w_sel_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;

    // Output slot: load a new grant when free or firing, drop valid when it drains empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_idx    <= w_sel;
            r_onehot <= w_sel_onehot;
        end else if (w_fire) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign idle       = ~|req;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: a fixed-priority N=8 instance, a
// round-robin N=8 instance and a round-robin N=5 instance share clock and reset.
// Lock sequences are compiled in when RRPE_LOCK_EN is defined.
module tb_rr_priority_encoder;

    logic       clk;
    logic       rst_n;

    logic [7:0] req0, oh0;
    logic [2:0] idx0;
    logic       rdy0, v0, idle0;

    logic [7:0] req1, oh1;
    logic [2:0] idx1;
    logic       rdy1, v1, idle1;

    logic [4:0] req2, oh2;
    logic [2:0] idx2;
    logic       rdy2, v2, idle2;

`ifdef RRPE_LOCK_EN
    logic       lock0, lock1, lock2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] eidx;
        logic [7:0] eoh;
        logic       eidle;
    } vec_t;

    vec_t tbl[11];

    rr_priority_encoder #(.N(8), .MODE(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n),
`ifdef RRPE_LOCK_EN
        .lock(lock0),
`endif
        .req(req0), .out_valid(v0), .out_ready(rdy0),
        .out_idx(idx0), .out_onehot(oh0), .idle(idle0)
    );

    rr_priority_encoder #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n),
`ifdef RRPE_LOCK_EN
        .lock(lock1),
`endif
        .req(req1), .out_valid(v1), .out_ready(rdy1),
        .out_idx(idx1), .out_onehot(oh1), .idle(idle1)
    );

    rr_priority_encoder #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n),
`ifdef RRPE_LOCK_EN
        .lock(lock2),
`endif
        .req(req2), .out_valid(v2), .out_ready(rdy2),
        .out_idx(idx2), .out_onehot(oh2), .idle(idle2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fixed-priority vectors, applied one per clock; outputs checked 1 ns after the edge.
        tbl[0]  = '{8'h26, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
        tbl[1]  = '{8'h06, 1'b1, 1'b1, 3'd2, 8'h04, 1'b0};
        tbl[2]  = '{8'h06, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0};
        tbl[3]  = '{8'h80, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0};
        tbl[4]  = '{8'h80, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
        tbl[7]  = '{8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
        tbl[8]  = '{8'hFF, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
        tbl[9]  = '{8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0};
        tbl[10] = '{8'h03, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};

        rst_n = 1'b0;
        req0 = '0; req1 = '0; req2 = '0;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
`ifdef RRPE_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0; lock2 = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_v0", int'(v0), 0);
        chk("rst_oh0", int'(oh0), 0);
        chk("rst_idx0", int'(idx0), 0);
        chk("rst_v1", int'(v1), 0);
        chk("rst_v2", int'(v2), 0);
        chk("rst_idle0", int'(idle0), 1);
        rst_n = 1'b1;

        // Fixed priority table
        for (int i = 0; i < 11; i++) begin
            req0 = tbl[i].req;
            rdy0 = tbl[i].rdy;
            tick();
            chk($sformatf("fix_v[%0d]", i), int'(v0), int'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("fix_idx[%0d]", i), int'(idx0), int'(tbl[i].eidx));
            chk($sformatf("fix_oh[%0d]", i), int'(oh0), int'(tbl[i].eoh));
            chk($sformatf("fix_idle[%0d]", i), int'(idle0), int'(tbl[i].eidle));
        end

        // Round-robin sweep over all lines with full throughput, then up to index 3
        req1 = 8'hFF;
        rdy1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("rr_v[%0d]", i), int'(v1), 1);
            chk($sformatf("rr_idx[%0d]", i), int'(idx1), i % 8);
            chk($sformatf("rr_oh[%0d]", i), int'(oh1), 1 << (i % 8));
        end

        // Stall on index 3 while req toggles, including withdrawal of line 3
        rdy1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req1 = (i % 2 == 0) ? 8'hF0 : 8'h08;
            tick();
            chk($sformatf("stall_v[%0d]", i), int'(v1), 1);
            chk($sformatf("stall_idx[%0d]", i), int'(idx1), 3);
            chk($sformatf("stall_oh[%0d]", i), int'(oh1), 8'h08);
        end
        req1 = 8'hFF;
        rdy1 = 1'b1;
        tick();
        chk("after_stall_idx", int'(idx1), 4);
        req1 = 8'h03;
        tick();
        chk("rr_wrap_search_idx", int'(idx1), 0);
        req1 = 8'h00;
        tick();
        chk("rr_drain_v", int'(v1), 0);
        chk("rr_drain_oh", int'(oh1), 0);
        chk("rr_idle", int'(idle1), 1);

        // N=5 round-robin wrap via compare
        req2 = 5'b10001;
        rdy2 = 1'b1;
        #1;
        chk("n5_idle_busy", int'(idle2), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("n5_v[%0d]", i), int'(v2), 1);
            chk($sformatf("n5_idx[%0d]", i), int'(idx2), (i % 2 == 0) ? 0 : 4);
            chk($sformatf("n5_oh[%0d]", i), int'(oh2), (i % 2 == 0) ? 5'b00001 : 5'b10000);
        end
        req2 = 5'b00000;
        #1;
        chk("n5_idle", int'(idle2), 1);
        tick();
        chk("n5_drain_v", int'(v2), 0);

        // Async reset during a stalled grant, and pointer cleared afterwards
        req0 = 8'h10;
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        tick();
        chk("pre_rst_v0", int'(v0), 1);
        chk("pre_rst_idx0", int'(idx0), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_v0", int'(v0), 0);
        chk("async_rst_oh0", int'(oh0), 0);
        tick();
        rst_n = 1'b1;
        req0 = 8'h00;
        req1 = 8'hFF;
        rdy1 = 1'b1;
        tick();
        chk("post_rst_ptr_idx1", int'(idx1), 0);
        chk("post_rst_v1", int'(v1), 1);

`ifdef RRPE_LOCK_EN
        // Lock: repeated grants of line 2 until it drops, then line 3
        req1 = 8'h00;
        tick();
        lock1 = 1'b1;
        req1 = 8'h0C;
        tick();
        chk("lock_first_idx", int'(idx1), 2);
        tick();
        chk("lock_rep1_idx", int'(idx1), 2);
        tick();
        chk("lock_rep2_idx", int'(idx1), 2);
        req1 = 8'h08;
        tick();
        chk("lock_drop_idx", int'(idx1), 3);
        tick();
        chk("lock_hold3_idx", int'(idx1), 3);
        lock0 = 1'b1;
        req0 = 8'h84;
        rdy0 = 1'b1;
        tick();
        chk("lock_fix_first", int'(idx0), 7);
        req0 = 8'hFF;
        tick();
        chk("lock_fix_rep", int'(idx0), 7);
        lock1 = 1'b0;
        lock0 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
